muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle HI/LO unit controller for the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
//  from the ID/EX pipeline and runs a radix-2 iterative multiply/divide.
//  Owns the architectural HI/LO registers. Raises a stall to the hazard logic while a new HI/LO op must wait.
// PARAMETERS
//  WIDTH   32   operand width; HI/LO each WIDTH bits; iteration count = WIDTH
// PORTS
//  clock       in   1      single clock domain
//  reset       in   1      synchronous, active-high
//  op_valid    in   1      HI/LO-class instruction present in EX this cycle
//  op          in   4      muldiv_pkg::md_op_t opcode
//  flush       in   1      exception flush of EX; suppresses acceptance this cycle
//  rs_data     in   WIDTH  forwarded Rs value (multiplicand/dividend, MTHI/MTLO source)
//  rt_data     in   WIDTH  forwarded Rt value (multiplier/divisor)
//  md_stall    out  1      combinational: op_valid & busy
//  busy        out  1      registered: iteration or fixup in progress
//  hi          out  WIDTH  architectural HI; MFHI reads this combinationally
//  lo          out  WIDTH  architectural LO; MFLO reads this combinationally
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, hi=0, lo=0, iteration counter=0. md_stall follows op_valid&busy, so it is 0 after reset.
//  Accept: at the edge where op_valid & !busy & !flush.
//    flush=1 drops the op; no state changes.
//    op_valid while busy: md_stall=1, the op is not accepted, and the pipeline holds it.
//  MTHI/MTLO: hi/lo <= rs_data at the accept edge; state stays IDLE.
//  MFHI/MFLO: no state change; the pipeline samples hi/lo. Stalled while busy.
//  MULT/MULTU/DIV/DIVU: at the accept edge, latch the operands.
//    Signed ops latch |operand| and the result signs.
//    State -> MUL or DIV; counter <= WIDTH-1; busy <= 1.
//  MUL: shift-add, one bit per cycle. Decrement the counter; at counter==0 -> FIXUP.
//  DIV: restoring divide, one quotient bit per cycle. Same counter rule.
//  FIXUP (1 cycle): apply sign correction.
//    Quotient negated if the operand signs differ; remainder takes the dividend's sign.
//    Product negated if the signs differ.
//    Write hi/lo (MUL: hi=upper, lo=lower; DIV: hi=remainder, lo=quotient); busy <= 0; -> IDLE.
//  Latency: accept at edge k; iterations at edges k+1..k+WIDTH; FIXUP at edge k+WIDTH+1.
//    New hi/lo and busy=0 are visible after edge k+WIDTH+1 (33 cycles at WIDTH=32).
//  hi/lo hold their old values during iteration; they are updated only at FIXUP.
//  Divide by zero: raw restoring output. lo=all ones (unsigned) and hi=dividend; signed fixup still applies.
//  Signed overflow (-2^(W-1) / -1): lo=0x8000_0000, hi=0.
//  flush or interrupt while busy: the in-flight op completes; flush affects acceptance only.
//  reset mid-operation: the op is abandoned; IDLE, hi=lo=0 at the next edge.
//  op_valid with a non-HI/LO op code: ignored; md_stall still follows op_valid&busy.
// CONFIGURATION
//  MULDIV_MADD_EN defined:
//    Adds MADD/MADDU/MSUB/MSUBU opcodes. The product is computed as for MULT/MULTU.
//    FIXUP then writes {hi,lo} <= {hi,lo} +/- product (2*WIDTH-bit wrap-around), using hi/lo as sampled at FIXUP.
//    Latency is unchanged.
//  MULDIV_MADD_EN undefined: those opcodes decode as invalid and are ignored (no accept, no state change).
// STRUCTURE
//  muldiv_pkg:
//    md_op_t enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO, MD_MADD,
//      MD_MADDU, MD_MSUB, MD_MSUBU).
//    md_state_t enum (MD_IDLE, MD_MUL, MD_DIV, MD_FIXUP).
//    localparam MD_OP_W=4.
//  Sub-module muldiv_iter: combinational single-step datapath (shift-add and trial-subtract, both WIDTH+1 bits).
//  The sequencer owns the FSM, counter, sign flags, operand/accumulator registers, and hi/lo.
// TESTING
//  MULT 7 x -3 at cycle 0:
//    busy=1 cycles 1..33; hi=0xFFFF_FFFF, lo=0xFFFF_FFEB after edge 33.
//  DIVU 100 / 7:
//    lo=14, hi=2 after 33 cycles.
//  DIV -7 / 2: lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
//  DIV 0x8000_0000 / -1: lo=0x8000_0000, hi=0.
//  DIVU 5 / 0: lo=0xFFFF_FFFF, hi=5.
//  MFLO at cycle 2 after MULT:
//    md_stall=1 through cycle 33; MFLO accepted cycle 34 and sees the product.
//    op_valid with flush=1: no accept, busy stays 0.
//  MTHI 0xDEAD_BEEF: hi updates next edge.
//    reset asserted mid-DIV at cycle 10: next edge busy=0, hi=lo=0, state IDLE.
//  With MULDIV_MADD_EN: hi:lo=0:10, MADD 3 x 4 -> lo=22.
//    MSUBU from 0:0 of 1 x 1 -> hi=lo=0xFFFF_FFFF.
//    Without the macro: MADD ignored, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: opcode and sequencer state encodings.
package muldiv_pkg;

    localparam int MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MTHI  = 4'd4,
        MD_MTLO  = 4'd5,
        MD_MFHI  = 4'd6,
        MD_MFLO  = 4'd7,
        MD_MADD  = 4'd8,
        MD_MADDU = 4'd9,
        MD_MSUB  = 4'd10,
        MD_MSUBU = 4'd11
    } md_op_t;

    // State names carry an S_ infix because MD_DIV is already taken by the opcode enum.
    typedef enum logic [1:0] {
        MD_S_IDLE  = 2'd0,
        MD_S_MUL   = 2'd1,
        MD_S_DIV   = 2'd2,
        MD_S_FIXUP = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Single-step datapath: one shift-add multiply step or one restoring-divide step per call.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] accHi,
    input  logic [WIDTH-1:0] accLo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);

    logic [WIDTH:0]   addSum;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        addSum  = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
        partial = {accHi, accLo[WIDTH-1]};
        fits    = partial >= {1'b0, operand};
        // When the trial subtract fits, the difference is below the divisor, so WIDTH bits suffice.
        diff    = partial[WIDTH-1:0] - operand;
        if (isDiv) begin
            nextHi = fits ? diff : partial[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], fits};
        end else begin
            nextHi = addSum[WIDTH:1];
            nextLo = {addSum[0], accLo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO unit controller: owns hi/lo and runs radix-2 iterative multiply/divide over WIDTH cycles.
// Defining MULDIV_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate opcodes.
//
// state      | meaning
// MD_S_IDLE  | waiting for an op; MTHI/MTLO write hi/lo directly
// MD_S_MUL   | one shift-add step per cycle, counter runs down to 0
// MD_S_DIV   | one restoring-divide step per cycle, counter runs down to 0
// MD_S_FIXUP | sign correction and hi/lo write-back, then back to idle
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  md_op_t           op,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             md_stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t        state, stateNext;
    md_op_t           curOp, curOpNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             busyReg, busyNext;
    logic [WIDTH-1:0] hiReg, hiNext;
    logic [WIDTH-1:0] loReg, loNext;
    logic [WIDTH-1:0] accHi, accHiNext;
    logic [WIDTH-1:0] accLo, accLoNext;
    logic [WIDTH-1:0] operand, operandNext;
    logic             negRes, negResNext;
    logic             negRem, negRemNext;
    logic [WIDTH-1:0] iterHi, iterLo;

    logic               accept, isMul, isDivOp, isMac, signedOp;
    logic [WIDTH-1:0]   absA, absB;
    logic [2*WIDTH-1:0] product;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .isDiv   (state == MD_S_DIV),
        .accHi   (accHi),
        .accLo   (accLo),
        .operand (operand),
        .nextHi  (iterHi),
        .nextLo  (iterLo)
    );

    always_comb begin
        isMul    = (op == MD_MULT) || (op == MD_MULTU);
        isDivOp  = (op == MD_DIV) || (op == MD_DIVU);
`ifdef MULDIV_MADD_EN
        isMac    = (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
        isMac    = 1'b0;
`endif
        signedOp = (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
        absA     = (signedOp && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        absB     = (signedOp && rt_data[WIDTH-1]) ? -rt_data : rt_data;
        accept   = op_valid && !busyReg && !flush;
        product  = negRes ? -{accHi, accLo} : {accHi, accLo};
    end

    always_comb begin
        stateNext   = state;
        curOpNext   = curOp;
        cntNext     = cnt;
        busyNext    = busyReg;
        hiNext      = hiReg;
        loNext      = loReg;
        accHiNext   = accHi;
        accLoNext   = accLo;
        operandNext = operand;
        negResNext  = negRes;
        negRemNext  = negRem;

        case (state)
            MD_S_IDLE: begin
                if (accept) begin
                    if (op == MD_MTHI) hiNext = rs_data;
                    if (op == MD_MTLO) loNext = rs_data;
                    if (isMul || isMac || isDivOp) begin
                        stateNext   = isDivOp ? MD_S_DIV : MD_S_MUL;
                        curOpNext   = op;
                        cntNext     = CNT_W'(WIDTH - 1);
                        busyNext    = 1'b1;
                        accHiNext   = '0;
                        accLoNext   = absA;
                        operandNext = absB;
                        negResNext  = signedOp && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        negRemNext  = signedOp && rs_data[WIDTH-1];
                    end
                end
            end
            MD_S_MUL, MD_S_DIV: begin
                accHiNext = iterHi;
                accLoNext = iterLo;
                if (cnt == '0) stateNext = MD_S_FIXUP;
                else           cntNext   = cnt - CNT_W'(1);
            end
            MD_S_FIXUP: begin
                if (curOp == MD_DIV || curOp == MD_DIVU) begin
                    // Quotient sign follows the operand signs, remainder follows the dividend.
                    loNext = negRes ? -accLo : accLo;
                    hiNext = negRem ? -accHi : accHi;
                end else begin
                    {hiNext, loNext} = product;
`ifdef MULDIV_MADD_EN
                    if (curOp == MD_MADD || curOp == MD_MADDU)
                        {hiNext, loNext} = {hiReg, loReg} + product;
                    if (curOp == MD_MSUB || curOp == MD_MSUBU)
                        {hiNext, loNext} = {hiReg, loReg} - product;
`endif
                end
                stateNext = MD_S_IDLE;
                busyNext  = 1'b0;
            end
            default: stateNext = MD_S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= MD_S_IDLE;
            curOp   <= MD_MULT;
            cnt     <= '0;
            busyReg <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
            accHi   <= '0;
            accLo   <= '0;
            operand <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
        end else begin
            state   <= stateNext;
            curOp   <= curOpNext;
            cnt     <= cntNext;
            busyReg <= busyNext;
            hiReg   <= hiNext;
            loReg   <= loNext;
            accHi   <= accHiNext;
            accLo   <= accLoNext;
            operand <= operandNext;
            negRes  <= negResNext;
            negRem  <= negRemNext;
        end
    end

    assign busy     = busyReg;
    assign hi       = hiReg;
    assign lo       = loReg;
    assign md_stall = op_valid & busyReg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus queues expected hi/lo, a monitor checks them
// when an op completes (busy falls) or when the stimulus requests a sample after an MTHI/MTLO-type op.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    md_op_t      op = MD_MFHI;
    logic        flush = 1'b0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        md_stall, busy;
    logic [31:0] hi, lo;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic        sampleNow = 1'b0;
    logic        prevBusy = 1'b0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .flush    (flush),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .md_stall (md_stall),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_hl(input string name, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.name = name;
        e.hi   = h;
        e.lo   = l;
        expQ.push_back(e);
        mHi = h;
        mLo = l;
    endtask

    task automatic issue(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        cycle();
        op_valid = 1'b0;
    endtask

    task automatic probe();
        sampleNow = 1'b1;
        @(negedge clock);
        #1;
        sampleNow = 1'b0;
    endtask

    // Count edges from just after the accept edge until busy drops.
    task automatic wait_done(input string name, input int already, input int reqCycles);
        int n = already;
        while (busy && n < 100) begin
            cycle();
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(reqCycles));
    endtask

    // Monitor: compare hi/lo whenever an op retires or the stimulus asks for a sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if ((prevBusy && !busy) || sampleNow) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got hi=%h lo=%h required no result", hi, lo);
                end else begin
                    e = expQ.pop_front();
                    check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                    check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                end
            end
            prevBusy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] oldHi, oldLo;

        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        op_valid = 1'b1;
        op       = MD_MFLO;
        #1;
        check("idle_stall", 64'(md_stall), 64'd0);
        op_valid = 1'b0;

        // MULT 7 x -3: hi/lo must hold through iteration
        oldHi = mHi;
        oldLo = mLo;
        expect_hl("mult_7_m3", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(MD_MULT, 32'd7, 32'hFFFF_FFFD);
        check("mult_busy_start", 64'(busy), 64'd1);
        repeat (5) cycle();
        check("mult_hold_hi", 64'(hi), 64'(oldHi));
        check("mult_hold_lo", 64'(lo), 64'(oldLo));
        wait_done("mult_7_m3", 5, 33);

        expect_hl("divu_100_7", 32'd2, 32'd14);
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_done("divu_100_7", 0, 33);

        expect_hl("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_m7_2", 0, 33);

        expect_hl("div_ovf", 32'h0, 32'h8000_0000);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 0, 33);

        expect_hl("divu_by0", 32'd5, 32'hFFFF_FFFF);
        issue(MD_DIVU, 32'd5, 32'd0);
        wait_done("divu_by0", 0, 33);

        expect_hl("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 0, 33);

        // Flush and a stalled MTHI while busy must not disturb the in-flight multiply
        expect_hl("mult_flushed", 32'h0, 32'h0123_4500);
        issue(MD_MULT, 32'h0001_2345, 32'h0000_0100);
        cycle();
        op_valid = 1'b1;
        op       = MD_MTHI;
        rs_data  = 32'h1111_1111;
        flush    = 1'b1;
        #1;
        check("busy_stall", 64'(md_stall), 64'd1);
        cycle();
        flush    = 1'b0;
        op_valid = 1'b0;
        wait_done("mult_flushed", 2, 33);

        // MFLO issued the cycle after MULT stalls until the product is visible
        expect_hl("mult_m2_m5", 32'h0, 32'd10);
        issue(MD_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFB);
        cycle();
        op_valid = 1'b1;
        op       = MD_MFLO;
        #1;
        n = 0;
        while (md_stall && n < 100) begin
            cycle();
            n++;
        end
        check("mflo_stall_cycles", 64'(n), 64'd32);
        check("mflo_sees_product", 64'(lo), 64'd10);
        cycle();
        op_valid = 1'b0;
        check("mflo_no_busy", 64'(busy), 64'd0);

        // Flushed ops are dropped
        op_valid = 1'b1;
        op       = MD_MULT;
        rs_data  = 32'd3;
        rt_data  = 32'd3;
        flush    = 1'b1;
        cycle();
        check("flush_no_busy", 64'(busy), 64'd0);
        op = MD_MTHI;
        rs_data = 32'h0000_0BAD;
        cycle();
        flush    = 1'b0;
        op_valid = 1'b0;
        expect_hl("flush_mthi_drop", mHi, mLo);
        probe();

        expect_hl("mthi", 32'hDEAD_BEEF, mLo);
        issue(MD_MTHI, 32'hDEAD_BEEF, 32'h0);
        probe();

        expect_hl("mtlo", mHi, 32'h0000_1234);
        issue(MD_MTLO, 32'h0000_1234, 32'h0);
        probe();

        expect_hl("invalid_op", mHi, mLo);
        issue(md_op_t'(4'hD), 32'h5555_5555, 32'h1);
        check("invalid_no_busy", 64'(busy), 64'd0);
        probe();

`ifdef MULDIV_MADD_EN
        expect_hl("madd_mthi", 32'h0, mLo);
        issue(MD_MTHI, 32'h0, 32'h0);
        probe();
        expect_hl("madd_mtlo", 32'h0, 32'd10);
        issue(MD_MTLO, 32'd10, 32'h0);
        probe();
        expect_hl("madd_3_4", 32'h0, 32'd22);
        issue(MD_MADD, 32'd3, 32'd4);
        wait_done("madd_3_4", 0, 33);
        expect_hl("msubu_mtlo", 32'h0, 32'h0);
        issue(MD_MTLO, 32'h0, 32'h0);
        probe();
        expect_hl("msubu_1_1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MD_MSUBU, 32'd1, 32'd1);
        wait_done("msubu_1_1", 0, 33);
`else
        expect_hl("madd_ignored", mHi, mLo);
        issue(MD_MADD, 32'd3, 32'd4);
        check("madd_no_busy", 64'(busy), 64'd0);
        probe();
`endif

        // Reset ten cycles into a divide abandons it
        expect_hl("reset_mid_div", 32'h0, 32'h0);
        issue(MD_DIV, 32'd1000, 32'd3);
        repeat (9) cycle();
        check("div_busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        cycle();
        check("reset_mid_busy", 64'(busy), 64'd0);
        check("reset_mid_hi", 64'(hi), 64'd0);
        check("reset_mid_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        repeat (3) cycle();
        check("scoreboard_drained", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
